// File: rtl/rrv64_l2tlb_req_arb_pkg.sv
// Shared widths, slot state codes and payload structs for the L2 TLB request
// arbiter. Optional feature macro: RRV64_L2TLB_ARB_ITLB_PRIO_EN.
package rrv64_l2tlb_req_arb_pkg;

  localparam int RRV64_L2TLB_MSHR_NUM        = 4;
  localparam int RRV64_VPN_WIDTH             = 27;
  localparam int RRV64_ASID_WIDTH            = 16;
  localparam int RRV64_PPN_WIDTH             = 44;
  localparam int RRV64_L1_TLB_TRANS_ID_WIDTH = 2;
  localparam int RRV64_L2TLB_SRC_W           = $clog2(RRV64_L2TLB_MSHR_NUM);

  typedef enum logic [1:0] {
    L2TLB_SLOT_IDLE = 2'd0,
    L2TLB_SLOT_PEND = 2'd1,
    L2TLB_SLOT_OUT  = 2'd2,
    L2TLB_SLOT_KILL = 2'd3
  } rrv64_l2tlb_slot_state_e;

  // plain constants of the same codes, used by the per-slot state registers
  localparam logic [1:0] ST_IDLE = L2TLB_SLOT_IDLE;
  localparam logic [1:0] ST_PEND = L2TLB_SLOT_PEND;
  localparam logic [1:0] ST_OUT  = L2TLB_SLOT_OUT;
  localparam logic [1:0] ST_KILL = L2TLB_SLOT_KILL;

  typedef struct packed {
    logic [RRV64_VPN_WIDTH-1:0]             vpn;
    logic [RRV64_ASID_WIDTH-1:0]            asid;
    logic [RRV64_L1_TLB_TRANS_ID_WIDTH-1:0] tid;
  } rrv64_l2tlb_req_t;

  typedef struct packed {
    logic [RRV64_PPN_WIDTH-1:0] ppn;
    logic                       fault;
    logic [1:0]                 lvl;
  } rrv64_l2tlb_resp_t;

endpackage

// File: rtl/rrv64_rr_arb.sv
// Round-robin arbiter with grant lock and pointer-update enable.
// Search starts one past the last handshaken index and wraps. While locked the
// previous grant is held regardless of newly arriving requests.
module rrv64_rr_arb #(
  parameter int N       = 4,
  parameter int PTR_RST = N - 1,
  localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          hold,     // keep the current grant next cycle
  input  logic          upd,      // downstream handshake: move pointer to grant
  output logic          gnt_vld,
  output logic [IW-1:0] gnt_idx,
  output logic          locked
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] lock_idx_q;
  logic          lock_q;
  logic [IW-1:0] rr_idx;
  logic          rr_vld;
  int            j;

  // first requester after the pointer, wrapping mod N
  always_comb begin
    rr_vld = 1'b0;
    rr_idx = '0;
    j      = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr_q) + k) % N;
      if (!rr_vld && req[IW'(j)]) begin
        rr_vld = 1'b1;
        rr_idx = IW'(j);
      end
    end
  end

  assign locked  = lock_q;
  assign gnt_vld = lock_q ? req[lock_idx_q] : rr_vld;
  assign gnt_idx = lock_q ? lock_idx_q : rr_idx;

  // pointer advances only on handshake; lock captures an unaccepted grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= IW'(PTR_RST);
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q <= hold;
      if (hold) lock_idx_q <= gnt_idx;
      if (upd)  ptr_q      <= gnt_idx;
    end
  end

endmodule

// File: rtl/rrv64_l2tlb_req_arb.sv
// L2 TLB request arbiter / response router. Four one-deep requester slots
// (0 ITLB, 1-2 DTLB, 3 S1/prefetch) compete for the single L2 lookup port and
// each gets its L2 response routed back one cycle after it arrives.
// Optional feature macro: RRV64_L2TLB_ARB_ITLB_PRIO_EN (slot 0 beats the
// round-robin whenever the grant is not locked).
module rrv64_l2tlb_req_arb
  import rrv64_l2tlb_req_arb_pkg::*;
#(
  parameter int REQ_N  = RRV64_L2TLB_MSHR_NUM,
  parameter int VPN_W  = RRV64_VPN_WIDTH,
  parameter int ASID_W = RRV64_ASID_WIDTH,
  parameter int PPN_W  = RRV64_PPN_WIDTH,
  parameter int TID_W  = RRV64_L1_TLB_TRANS_ID_WIDTH,
  localparam int SRC_W = $clog2(REQ_N)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [REQ_N-1:0]              req_vld_i,
  output logic [REQ_N-1:0]              req_rdy_o,
  input  logic [REQ_N-1:0][VPN_W-1:0]   req_vpn_i,
  input  logic [REQ_N-1:0][ASID_W-1:0]  req_asid_i,
  input  logic [REQ_N-1:0][TID_W-1:0]   req_tid_i,
  output logic                          l2_req_vld_o,
  input  logic                          l2_req_rdy_i,
  output logic [VPN_W-1:0]              l2_req_vpn_o,
  output logic [ASID_W-1:0]             l2_req_asid_o,
  output logic [TID_W-1:0]              l2_req_tid_o,
  output logic [SRC_W-1:0]              l2_req_src_o,
  input  logic                          l2_resp_vld_i,
  input  logic [SRC_W-1:0]              l2_resp_src_i,
  input  logic [PPN_W-1:0]              l2_resp_ppn_i,
  input  logic                          l2_resp_fault_i,
  input  logic [1:0]                    l2_resp_lvl_i,
  output logic [REQ_N-1:0]              resp_vld_o,
  output logic [REQ_N-1:0][TID_W-1:0]   resp_tid_o,
  output logic [REQ_N-1:0][PPN_W-1:0]   resp_ppn_o,
  output logic [REQ_N-1:0]              resp_fault_o,
  output logic [REQ_N-1:0][1:0]         resp_lvl_o
);

  logic [REQ_N-1:0]                   pend;
  logic [REQ_N-1:0]                   rsp_ok;
  rrv64_l2tlb_req_t [REQ_N-1:0]       slot_req;
  logic                               gnt_vld;
  logic [SRC_W-1:0]                   gnt_idx;
  logic                               l2_hs;
  logic                               arb_locked;
  rrv64_l2tlb_req_t                   gnt_req;

  assign l2_hs = gnt_vld & l2_req_rdy_i;

`ifdef RRV64_L2TLB_ARB_ITLB_PRIO_EN
  localparam int SUB_W = (REQ_N - 1 > 1) ? $clog2(REQ_N - 1) : 1;
  logic             sub_vld;
  logic [SUB_W-1:0] sub_idx;
  logic             itlb_win;

  // slots 1..N-1 rotate; ITLB overrides unless that rotation holds a lock
  assign itlb_win = pend[0] & ~arb_locked;
  assign gnt_vld  = itlb_win | sub_vld;
  assign gnt_idx  = itlb_win ? '0 : SRC_W'(sub_idx) + SRC_W'(1);

  rrv64_rr_arb #(.N(REQ_N - 1), .PTR_RST(REQ_N - 2)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (pend[REQ_N-1:1]),
    .hold    (sub_vld & ~itlb_win & ~l2_req_rdy_i & ~flush),
    .upd     (l2_hs & ~itlb_win),
    .gnt_vld (sub_vld),
    .gnt_idx (sub_idx),
    .locked  (arb_locked)
  );
`else
  rrv64_rr_arb #(.N(REQ_N), .PTR_RST(REQ_N - 1)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (pend),
    .hold    (gnt_vld & ~l2_req_rdy_i & ~flush),
    .upd     (l2_hs),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx),
    .locked  (arb_locked)
  );
`endif

  // payload is zeroed when nothing is granted so idle outputs stay quiet
  assign gnt_req       = gnt_vld ? slot_req[gnt_idx] : '0;
  assign l2_req_vld_o  = gnt_vld;
  assign l2_req_src_o  = gnt_vld ? gnt_idx : '0;
  assign l2_req_vpn_o  = gnt_req.vpn;
  assign l2_req_asid_o = gnt_req.asid;
  assign l2_req_tid_o  = gnt_req.tid;

  for (genvar i = 0; i < REQ_N; i++) begin : g_slot
    logic [1:0]        st_q;
    rrv64_l2tlb_req_t  req_q;
    logic              vld_q;
    rrv64_l2tlb_resp_t rsp_q;
    logic [TID_W-1:0]  tid_q;
    logic              acc, hs, rsp, dlv;

    assign req_rdy_o[i] = (st_q == ST_IDLE) & ~flush;
    assign pend[i]      = (st_q == ST_PEND);
    assign rsp_ok[i]    = (st_q == ST_OUT) | (st_q == ST_KILL);
    assign acc          = req_vld_i[i] & req_rdy_o[i];
    assign hs           = l2_hs & (gnt_idx == SRC_W'(i));
    assign rsp          = l2_resp_vld_i & (l2_resp_src_i == SRC_W'(i));
    assign dlv          = rsp & (st_q == ST_OUT);
    assign slot_req[i]  = req_q;

    // slot lifecycle; a handshake in the flush cycle still goes out, then is killed
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q  <= ST_IDLE;
        req_q <= '0;
      end else begin
        case (st_q)
          ST_IDLE: if (acc) begin
            st_q       <= ST_PEND;
            req_q.vpn  <= req_vpn_i[i];
            req_q.asid <= req_asid_i[i];
            req_q.tid  <= req_tid_i[i];
          end
          ST_PEND: begin
            if (hs)         st_q <= flush ? ST_KILL : ST_OUT;
            else if (flush) st_q <= ST_IDLE;
          end
          ST_OUT: begin
            if (rsp)        st_q <= ST_IDLE;
            else if (flush) st_q <= ST_KILL;
          end
          default: if (rsp) st_q <= ST_IDLE;
        endcase
      end
    end

    // registered response pulse; payload holds until the next delivery
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        rsp_q <= '0;
        tid_q <= '0;
      end else begin
        vld_q <= dlv;
        if (dlv) begin
          rsp_q.ppn   <= l2_resp_ppn_i;
          rsp_q.fault <= l2_resp_fault_i;
          rsp_q.lvl   <= l2_resp_lvl_i;
          tid_q       <= req_q.tid;
        end
      end
    end

    assign resp_vld_o[i]   = vld_q;
    assign resp_tid_o[i]   = tid_q;
    assign resp_ppn_o[i]   = rsp_q.ppn;
    assign resp_fault_o[i] = rsp_q.fault;
    assign resp_lvl_o[i]   = rsp_q.lvl;
  end

  // responses may only target a slot with a request outstanding downstream
  a_no_stray_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    !(l2_resp_vld_i && !rsp_ok[l2_resp_src_i]));

  // a locked grant always refers to a slot that is still pending
  a_lock_pending: assert property (@(posedge clk) disable iff (!rst_n)
    !arb_locked || gnt_vld);

endmodule
